// File: rtl/rm_lane_sequencer.sv
`default_nettype none
// ============================================================================
// rm_lane_sequencer : per-lane ordered-event sequencer with match-record FIFO
// Revision 1.0
// ============================================================================
module rm_lane_sequencer #(
    parameter int NUM_LANES  = 5,
    parameter int SEQ_LEN    = 4,
    parameter int TIMEOUT    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 probe_val_i,
    input  logic [LW-1:0]        lane_i,
    input  logic                 reset_lane_i,
    output logic                 match_valid_o,
    input  logic                 match_ready_i,
    output logic [LW-1:0]        match_lane_o,
    output logic [CNT_W-1:0]     match_stamp_o,
    output logic [NUM_LANES-1:0] armed_o,
    output logic [NUM_LANES-1:0] timeout_mask_o,
    output logic [CNT_W-1:0]     total_matches_o,
    output logic                 overflow_o
);

    localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN + 1) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = LW + CNT_W;

    typedef enum logic {
        LANE_IDLE  = 1'b0,
        LANE_ARMED = 1'b1
    } lane_state_t;

    logic [NUM_LANES-1:0] complete_vec;
    logic [NUM_LANES-1:0] timeout_vec;

    // ------------------------------------------------------------------
    // Per-lane sequence tracking
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_state_t   state_q, state_d;
        logic [SW-1:0] step_q, step_d;
        logic [TW-1:0] timer_q, timer_d;
        logic          hit;
        logic          complete;
        logic          expire;

        // Out-of-range lane indices never match any lane, so they are ignored.
        assign hit = (lane_i == LW'(i));

        always_comb begin
            state_d  = state_q;
            step_d   = step_q;
            timer_d  = timer_q;
            complete = 1'b0;
            expire   = 1'b0;
            if (hit && reset_lane_i) begin
                state_d = LANE_IDLE;
                step_d  = '0;
                timer_d = '0;
            end else if (hit && probe_val_i) begin
                timer_d = '0;
                if (step_q == SW'(SEQ_LEN - 1)) begin
                    state_d  = LANE_IDLE;
                    step_d   = '0;
                    complete = 1'b1;
                end else begin
                    state_d = LANE_ARMED;
                    step_d  = step_q + 1'b1;
                end
            end else if (state_q == LANE_ARMED) begin
                if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = LANE_IDLE;
                    step_d  = '0;
                    timer_d = '0;
                    expire  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q <= LANE_IDLE;
                step_q  <= '0;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                step_q  <= step_d;
                timer_q <= timer_d;
            end
        end

        assign complete_vec[i] = complete;
        assign timeout_vec[i]  = expire;
        assign armed_o[i]      = (state_q == LANE_ARMED);
    end

    // ------------------------------------------------------------------
    // Match-record FIFO and counters
    // ------------------------------------------------------------------
    logic [RW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             empty, full, push, pop, push_ok;
    logic [RW-1:0]    head;
    logic [CNT_W-1:0] total_q;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push    = |complete_vec;
    assign pop     = !empty && match_ready_i;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= {lane_i, total_q};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr           <= '0;
            rptr           <= '0;
            total_q        <= '0;
            overflow_o     <= 1'b0;
            timeout_mask_o <= '0;
        end else begin
            timeout_mask_o <= timeout_vec;
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow_o <= 1'b1;
            end
            if (push && (total_q != {CNT_W{1'b1}})) begin
                total_q <= total_q + 1'b1;
            end
        end
    end

    assign match_valid_o   = !empty;
    assign match_lane_o    = empty ? '0 : head[RW-1:CNT_W];
    assign match_stamp_o   = empty ? '0 : head[CNT_W-1:0];
    assign total_matches_o = total_q;

endmodule
`default_nettype wire
